isa_cycle_master: RTL and testbench

//  ISA bus initiator: turns single-beat CPU-side requests into ISA I/O and memory

---
 rtl/isa_cycle_master_if.sv | 41 ++++
 rtl/isa_cycle_master.sv | 164 ++++++++++++++++
 tb/tb_isa_cycle_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/isa_cycle_master_if.sv
// CPU-side request/ack signals and ISA bus signals of the ISA cycle initiator.
interface isa_cycle_master_if;
  // CPU side
  logic        req;
  logic        req_io;
  logic        req_write;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  // ISA side
  logic [19:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_din;
  logic        bus_dir;
  logic        bus_rdy;

  modport master (
    input  req, req_io, req_write, req_addr, req_wdata,
    output ack, rdata, err, busy,
    output bus_a, bus_d_out, bus_d_oe,
    output bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    input  bus_din, bus_dir, bus_rdy
  );

  modport slave (
    output req, req_io, req_write, req_addr, req_wdata,
    input  ack, rdata, err, busy,
    input  bus_a, bus_d_out, bus_d_oe,
    input  bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    output bus_din, bus_dir, bus_rdy
  );
endinterface

// File: rtl/isa_cycle_master.sv
// ISA bus initiator: one CPU request -> one ISA I/O or memory cycle with
// setup / strobe / hold phases, RDY wait states with timeout, and read capture.
// All outputs are registered from the next-state decode, so each output value
// belongs to the state that the FSM is in during that clock.
module isa_cycle_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned RDY_TIMEOUT   = 64,
  parameter logic [7:0]  FLOAT_DATA    = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  isa_cycle_master_if.master  isa
);

  localparam int unsigned CNT_MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_SH > STROBE_CYCLES) ? CNT_MAX_SH : STROBE_CYCLES;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);
  localparam int unsigned WW         = $clog2(RDY_TIMEOUT + 1);
  localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES);
  localparam logic [WW-1:0] C_TO     = WW'(RDY_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic          r_terr, w_terr_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          w_latch;
  logic          w_active;
  logic          w_strobe;
  logic          w_io_eff;
  logic          w_write_eff;

  logic          r_io, r_write;
  logic          r_ack, r_err, r_busy;
  logic [19:0]   r_bus_a;
  logic [7:0]    r_d_out;
  logic          r_d_oe, r_aen;
  logic          r_ior_l, r_iow_l, r_memr_l, r_memw_l;

  // Next-state, counters, timeout flag and read capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_terr_nxt  = r_terr;
    w_rdata_nxt = r_rdata;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (isa.req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CW'(1);
          w_wait_nxt  = '0;
          w_terr_nxt  = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt >= C_SETUP) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STROBE: begin
        // RDY is only looked at once the minimum strobe width has elapsed
        if (r_cnt < C_STROBE) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (isa.bus_rdy || (r_wait >= C_TO)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CW'(1);
          w_terr_nxt  = ~isa.bus_rdy;
          if (!r_write)
            w_rdata_nxt = isa.bus_dir ? isa.bus_din : FLOAT_DATA;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt >= C_HOLD)
          w_state_nxt = S_DONE;
        else
          w_cnt_nxt = r_cnt + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode for the clock that follows the coming edge
  always_comb begin
    w_active    = (w_state_nxt != S_IDLE);
    w_strobe    = (w_state_nxt == S_STROBE);
    w_io_eff    = w_latch ? isa.req_io    : r_io;
    w_write_eff = w_latch ? isa.req_write : r_write;
  end

  // State, counters and registered bus/CPU outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wait   <= '0;
      r_terr   <= 1'b0;
      r_rdata  <= '0;
      r_io     <= 1'b0;
      r_write  <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_bus_a  <= '0;
      r_d_out  <= '0;
      r_d_oe   <= 1'b0;
      r_aen    <= 1'b1;
      r_ior_l  <= 1'b1;
      r_iow_l  <= 1'b1;
      r_memr_l <= 1'b1;
      r_memw_l <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      r_terr  <= w_terr_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_latch) begin
        r_io    <= isa.req_io;
        r_write <= isa.req_write;
        r_bus_a <= isa.req_addr;
        if (isa.req_write)
          r_d_out <= isa.req_wdata;
      end
      r_ack    <= (w_state_nxt == S_DONE);
      r_err    <= (w_state_nxt == S_DONE) && w_terr_nxt;
      r_busy   <= w_active;
      r_aen    <= ~w_active;
      r_d_oe   <= w_active && w_write_eff;
      r_ior_l  <= ~(w_strobe &&  w_io_eff && !w_write_eff);
      r_iow_l  <= ~(w_strobe &&  w_io_eff &&  w_write_eff);
      r_memr_l <= ~(w_strobe && !w_io_eff && !w_write_eff);
      r_memw_l <= ~(w_strobe && !w_io_eff &&  w_write_eff);
    end
  end

  assign isa.ack        = r_ack;
  assign isa.rdata      = r_rdata;
  assign isa.err        = r_err;
  assign isa.busy       = r_busy;
  assign isa.bus_a      = r_bus_a;
  assign isa.bus_d_out  = r_d_out;
  assign isa.bus_d_oe   = r_d_oe;
  assign isa.bus_aen    = r_aen;
  assign isa.bus_ior_l  = r_ior_l;
  assign isa.bus_iow_l  = r_iow_l;
  assign isa.bus_memr_l = r_memr_l;
  assign isa.bus_memw_l = r_memw_l;

endmodule

// File: tb/tb_isa_cycle_master.sv
// Directed bench for isa_cycle_master: I/O and memory cycles, wait states,
// RDY timeout, floating reads, mid-cycle reset and back-to-back requests.
module tb_isa_cycle_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  isa_cycle_master_if ifc();

  isa_cycle_master #(
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(4),
    .HOLD_CYCLES  (1),
    .RDY_TIMEOUT  (64),
    .FLOAT_DATA   (8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .isa  (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector ordering: {ior, iow, memr, memw}, 1 = low
  function automatic logic [3:0] lows();
    return {~ifc.bus_ior_l, ~ifc.bus_iow_l, ~ifc.bus_memr_l, ~ifc.bus_memw_l};
  endfunction

  // Issue one request and observe it at each falling edge k = 1, 2, ...
  // after the accepting edge. bus_rdy is 0 for k in [lo_s, lo_e].
  task automatic run(input logic io, input logic wr, input logic [19:0] a,
                     input logic [7:0] wd, input int lo_s, input int lo_e,
                     output int n_lo, output int first_lo, output int ack_k,
                     output logic err_o, output logic [7:0] rd_o, output int viol,
                     output logic [3:0] which, output logic [19:0] a_o,
                     output logic [7:0] dout_o, output logic doe_o);
    logic [3:0] l;
    ifc.req = 1'b1; ifc.req_io = io; ifc.req_write = wr;
    ifc.req_addr = a; ifc.req_wdata = wd; ifc.bus_rdy = 1'b1;
    n_lo = 0; first_lo = -1; ack_k = -1; viol = 0; which = '0;
    err_o = 1'bx; rd_o = 'x; a_o = 'x; dout_o = 'x; doe_o = 1'bx;
    for (int k = 1; k <= 120 && ack_k < 0; k++) begin
      @(negedge clk);
      ifc.bus_rdy = !(k >= lo_s && k <= lo_e);
      l = lows();
      if ($countones(l) > 1) viol++;
      if (l != 0 && ifc.bus_aen) viol++;
      if (l != 0) begin
        n_lo++;
        which |= l;
        if (first_lo < 0) begin
          first_lo = k; a_o = ifc.bus_a; dout_o = ifc.bus_d_out; doe_o = ifc.bus_d_oe;
        end
      end
      if (ifc.ack) begin
        ack_k = k; err_o = ifc.err; rd_o = ifc.rdata; ifc.req = 1'b0;
      end
    end
    ifc.req = 1'b0;
    ifc.bus_rdy = 1'b1;
  endtask

  int         n_lo, first_lo, ack_k, viol, acks, prev_ack, aen_hi;
  logic       err_o, doe_o;
  logic [7:0] rd_o, dout_o;
  logic [3:0] which;
  logic [19:0] a_o;

  initial begin
    ifc.req = 1'b0; ifc.req_io = 1'b0; ifc.req_write = 1'b0;
    ifc.req_addr = '0; ifc.req_wdata = '0;
    ifc.bus_din = '0; ifc.bus_dir = 1'b0; ifc.bus_rdy = 1'b1;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_strobes", {28'd0, lows()}, 32'h0);
    chk("rst_aen", ifc.bus_aen, 1);
    chk("rst_doe", ifc.bus_d_oe, 0);
    chk("rst_bus_a", ifc.bus_a, 0);
    chk("rst_dout", ifc.bus_d_out, 0);
    chk("rst_ack_err_busy", {ifc.ack, ifc.err, ifc.busy}, 0);
    chk("rst_rdata", ifc.rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // I/O write 0x3D8 <= 0x09; RDY low during the minimum width is ignored
    run(1'b1, 1'b1, 20'h003D8, 8'h09, 2, 4, n_lo, first_lo, ack_k, err_o, rd_o,
        viol, which, a_o, dout_o, doe_o);
    chk("iow_first_lo", first_lo, 2);
    chk("iow_width", n_lo, 4);
    chk("iow_which", which, 4'b0100);
    chk("iow_ack_k", ack_k, 7);
    chk("iow_err", err_o, 0);
    chk("iow_bus_a", a_o, 20'h003D8);
    chk("iow_dout", dout_o, 8'h09);
    chk("iow_doe", doe_o, 1);
    chk("iow_viol", viol, 0);
    @(negedge clk);
    chk("iow_after_aen", ifc.bus_aen, 1);
    chk("iow_after_busy_doe_ack", {ifc.busy, ifc.bus_d_oe, ifc.ack}, 0);

    // I/O read 0x3DA, responder drives 0xF9
    ifc.bus_din = 8'hF9; ifc.bus_dir = 1'b1;
    run(1'b1, 1'b0, 20'h003DA, 8'h00, 0, -1, n_lo, first_lo, ack_k, err_o, rd_o,
        viol, which, a_o, dout_o, doe_o);
    chk("ior_width", n_lo, 4);
    chk("ior_which", which, 4'b1000);
    chk("ior_ack_k", ack_k, 7);
    chk("ior_rdata", rd_o, 8'hF9);
    chk("ior_doe", doe_o, 0);
    @(negedge clk);

    // Memory read 0xB8000 with 10 wait clocks after the minimum width
    ifc.bus_din = 8'h5A;
    run(1'b0, 1'b0, 20'hB8000, 8'h00, 5, 14, n_lo, first_lo, ack_k, err_o, rd_o,
        viol, which, a_o, dout_o, doe_o);
    chk("memr_width", n_lo, 14);
    chk("memr_which", which, 4'b0010);
    chk("memr_ack_k", ack_k, 17);
    chk("memr_err", err_o, 0);
    chk("memr_rdata", rd_o, 8'h5A);
    chk("memr_bus_a", a_o, 20'hB8000);
    @(negedge clk);

    // Memory write with RDY stuck low: timeout after 4+64 clocks
    run(1'b0, 1'b1, 20'hB8002, 8'h41, 1, 1000, n_lo, first_lo, ack_k, err_o, rd_o,
        viol, which, a_o, dout_o, doe_o);
    chk("memw_to_width", n_lo, 68);
    chk("memw_to_which", which, 4'b0001);
    chk("memw_to_ack_k", ack_k, 71);
    chk("memw_to_err", err_o, 1);
    chk("memw_to_rdata_kept", rd_o, 8'h5A);
    chk("memw_to_viol", viol, 0);
    @(negedge clk);
    chk("memw_to_err_drops", ifc.err, 0);

    // Unmapped I/O read 0x3F0, nobody drives: float value, err cleared
    ifc.bus_dir = 1'b0; ifc.bus_din = 8'h12;
    run(1'b1, 1'b0, 20'h003F0, 8'h00, 0, -1, n_lo, first_lo, ack_k, err_o, rd_o,
        viol, which, a_o, dout_o, doe_o);
    chk("float_rdata", rd_o, 8'hFF);
    chk("float_err", err_o, 0);
    chk("float_ack_k", ack_k, 7);
    @(negedge clk);

    // Reset asserted mid-STROBE
    ifc.req = 1'b1; ifc.req_io = 1'b1; ifc.req_write = 1'b0; ifc.req_addr = 20'h003F0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midrst_lo_before", ifc.bus_ior_l, 0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_strobes", {28'd0, lows()}, 32'h0);
    chk("midrst_aen", ifc.bus_aen, 1);
    ifc.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc.ack) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    chk("midrst_idle_busy", ifc.busy, 0);

    // req held high: back-to-back cycles, one idle AEN-high clock between
    ifc.req = 1'b1; ifc.req_io = 1'b1; ifc.req_write = 1'b1;
    ifc.req_addr = 20'h003D9; ifc.req_wdata = 8'h2C; ifc.bus_rdy = 1'b1;
    acks = 0; prev_ack = -1; viol = 0; aen_hi = 0;
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      if ($countones(lows()) > 1) viol++;
      if (lows() != 0 && ifc.bus_aen) viol++;
      if (ifc.bus_aen) aen_hi++;
      if (ifc.ack) begin
        if (prev_ack < 0) chk("b2b_first_ack", k, 7);
        else chk("b2b_ack_interval", k - prev_ack, 8);
        prev_ack = k;
        acks++;
      end
    end
    ifc.req = 1'b0;
    chk("b2b_ack_count", acks, 5);
    chk("b2b_aen_high_clocks", aen_hi, 4);
    chk("b2b_viol", viol, 0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("b2b_final_idle", {ifc.busy, ifc.bus_aen}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
